// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. It issues one word-aligned request at a time to the
// instruction memory, waits for the read data, and passes the returned word and
// its address to decode. A one-entry buffer holds a returned word while decode
// is stalled. Redirects (branch, jump or flush) abandon the work in progress
// and restart fetching at the new target.
//
// Parameters
//   XLEN       datapath and PC width
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  instruction presented to decode on bubbles
//
// Ports
//   clk             sole clock, rising edge
//   rst_n           asynchronous, active-low reset
//   imem_req        fetch request valid
//   imem_addr       fetch address, always word aligned
//   imem_gnt        memory accepted the request this cycle
//   imem_rvalid     memory read data valid
//   imem_rdata      returned instruction word
//   redirect_valid  redirect request; overrides stall
//   redirect_pc     redirect target (low two bits ignored)
//   stall           decode is not accepting; hold id outputs
//   id_valid        id_instr / id_pc hold a real instruction
//   id_instr        instruction for decode
//   id_pc           address of id_instr
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            kill, kill_next;
  logic [31:0]     buf_instr, buf_instr_next;
  logic [XLEN-1:0] buf_pc, buf_pc_next;
  logic            id_valid_next;
  logic [31:0]     id_instr_next;
  logic [XLEN-1:0] id_pc_next;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;

  // Wraps naturally modulo 2^XLEN.
  assign pc_plus4        = pc + XLEN'(4);
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // Request outputs depend only on registered state (rst_n gating keeps the
  // request low while reset is held); never on the memory response.
  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc & ALIGN_MASK;

  // Next-state and datapath decisions.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    kill_next      = kill;
    buf_instr_next = buf_instr;
    buf_pc_next    = buf_pc;
    id_valid_next  = id_valid;
    id_instr_next  = id_instr;
    id_pc_next     = id_pc;

    // Unstalled decode sees a bubble unless something is delivered below.
    if (!stall) begin
      id_valid_next = 1'b0;
      id_instr_next = NOP_INSTR;
    end

    case (state)
      S_REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          // A request granted in the same cycle is for the old address; its
          // response must be thrown away.
          if (imem_gnt) begin
            state_next = S_WAIT;
            kill_next  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid || kill) begin
            state_next = S_REQ;
            kill_next  = 1'b0;
          end else if (stall) begin
            buf_instr_next = imem_rdata;
            buf_pc_next    = pc;
            state_next     = S_HOLD;
          end else begin
            id_valid_next = 1'b1;
            id_instr_next = imem_rdata;
            id_pc_next    = pc;
            pc_next       = pc_plus4;
            state_next    = S_REQ;
          end
        end else if (redirect_valid) begin
          // Response still in flight; remember to discard it.
          kill_next = 1'b1;
        end
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (!stall) begin
          id_valid_next = 1'b1;
          id_instr_next = buf_instr;
          id_pc_next    = buf_pc;
          pc_next       = pc_plus4;
          state_next    = S_REQ;
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase

    // Redirect flushes decode even when it is stalled.
    if (redirect_valid) begin
      id_valid_next = 1'b0;
      id_instr_next = NOP_INSTR;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC & ALIGN_MASK;
      kill      <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
      id_valid  <= 1'b0;
      id_instr  <= NOP_INSTR;
      id_pc     <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      kill      <= kill_next;
      buf_instr <= buf_instr_next;
      buf_pc    <= buf_pc_next;
      id_valid  <= id_valid_next;
      id_instr  <= id_instr_next;
      id_pc     <= id_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Cycle-by-cycle vector bench for fetch_unit. Each table row gives the inputs
// driven in one cycle and the outputs expected during that cycle. Expected
// outputs are queued when a row is driven and popped when the DUT outputs are
// sampled, halfway between rising edges. Hand-written sequences follow for
// reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        idv;
    logic [31:0] idi;
    logic [31:0] idpc;
  } out_t;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    out_t        exp;
  } vec_t;

  out_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  vec_t vecs[30];

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc, input logic stl,
                              input logic req, input logic [31:0] addr, input logic idv,
                              input logic [31:0] idi, input logic [31:0] idpc);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.redir = redir; v.rpc = rpc; v.stl = stl;
    v.exp = '{req: req, addr: addr, idv: idv, idi: idi, idpc: idpc};
    return v;
  endfunction

  // Drive one cycle of inputs and queue what the outputs should be.
  task automatic applyStimulus(input vec_t v);
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rv;
    imem_rdata     = v.rdata;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    stall          = v.stl;
    sb.push_back(v.exp);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic checkOutput(input string name);
    out_t exp;
    out_t act;
    act = '{req: imem_req, addr: imem_addr, idv: id_valid, idi: id_instr, idpc: id_pc};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: no expectation queued", name);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got req=%0b addr=%h idv=%0b instr=%h pc=%h, want req=%0b addr=%h idv=%0b instr=%h pc=%h",
                 name, act.req, act.addr, act.idv, act.idi, act.idpc,
                 exp.req, exp.addr, exp.idv, exp.idi, exp.idpc);
      end
    end
  endtask

  initial begin
    // Main sequence: gnt/rvalid inputs | expected req addr id_valid id_instr id_pc
    vecs[0]  = mk(1, 0, 0,            0, 0,            0,  1, 32'h0,        0, NOP,          32'h0);
    vecs[1]  = mk(0, 1, 32'h00500093, 0, 0,            0,  0, 32'h0,        0, NOP,          32'h0);
    vecs[2]  = mk(1, 0, 0,            0, 0,            0,  1, 32'h4,        1, 32'h00500093, 32'h0);
    vecs[3]  = mk(0, 1, 32'h00A00113, 0, 0,            0,  0, 32'h4,        0, NOP,          32'h0);
    vecs[4]  = mk(1, 0, 0,            0, 0,            1,  1, 32'h8,        1, 32'h00A00113, 32'h4);
    vecs[5]  = mk(0, 1, 32'h00308193, 0, 0,            1,  0, 32'h8,        1, 32'h00A00113, 32'h4);
    vecs[6]  = mk(0, 0, 0,            0, 0,            1,  0, 32'h8,        1, 32'h00A00113, 32'h4);
    vecs[7]  = mk(0, 0, 0,            0, 0,            1,  0, 32'h8,        1, 32'h00A00113, 32'h4);
    vecs[8]  = mk(0, 0, 0,            0, 0,            0,  0, 32'h8,        1, 32'h00A00113, 32'h4);
    vecs[9]  = mk(0, 0, 0,            0, 0,            0,  1, 32'hC,        1, 32'h00308193, 32'h8);
    vecs[10] = mk(1, 0, 0,            0, 0,            0,  1, 32'hC,        0, NOP,          32'h8);
    vecs[11] = mk(0, 0, 0,            1, 32'h103,      0,  0, 32'hC,        0, NOP,          32'h8);
    vecs[12] = mk(0, 1, 32'hDEADBEEF, 0, 0,            0,  0, 32'h100,      0, NOP,          32'h8);
    vecs[13] = mk(1, 0, 0,            0, 0,            0,  1, 32'h100,      0, NOP,          32'h8);
    vecs[14] = mk(0, 1, 32'h00000513, 0, 0,            0,  0, 32'h100,      0, NOP,          32'h8);
    vecs[15] = mk(1, 0, 0,            0, 0,            1,  1, 32'h104,      1, 32'h00000513, 32'h100);
    vecs[16] = mk(0, 1, 32'h12345678, 1, 32'h200,      1,  0, 32'h104,      1, 32'h00000513, 32'h100);
    vecs[17] = mk(1, 0, 0,            1, 32'hFFFFFFFC, 0,  1, 32'h200,      0, NOP,          32'h100);
    vecs[18] = mk(0, 1, 32'h00000BAD, 0, 0,            0,  0, 32'hFFFFFFFC, 0, NOP,          32'h100);
    vecs[19] = mk(1, 0, 0,            0, 0,            0,  1, 32'hFFFFFFFC, 0, NOP,          32'h100);
    vecs[20] = mk(0, 1, 32'h00100073, 0, 0,            0,  0, 32'hFFFFFFFC, 0, NOP,          32'h100);
    vecs[21] = mk(1, 0, 0,            0, 0,            0,  1, 32'h0,        1, 32'h00100073, 32'hFFFFFFFC);
    vecs[22] = mk(0, 0, 0,            0, 0,            0,  0, 32'h0,        0, NOP,          32'hFFFFFFFC);
    vecs[23] = mk(0, 1, 32'h00000001, 0, 0,            1,  0, 32'h0,        0, NOP,          32'hFFFFFFFC);
    vecs[24] = mk(0, 0, 0,            1, 32'h40,       1,  0, 32'h0,        0, NOP,          32'hFFFFFFFC);
    vecs[25] = mk(0, 0, 0,            1, 32'h80,       0,  1, 32'h40,       0, NOP,          32'hFFFFFFFC);
    vecs[26] = mk(1, 0, 0,            0, 0,            0,  1, 32'h80,       0, NOP,          32'hFFFFFFFC);
    vecs[27] = mk(0, 1, 32'h00000297, 0, 0,            0,  0, 32'h80,       0, NOP,          32'hFFFFFFFC);
    vecs[28] = mk(1, 0, 0,            0, 0,            0,  1, 32'h84,       1, 32'h00000297, 32'h80);
    vecs[29] = mk(0, 0, 0,            0, 0,            0,  0, 32'h84,       0, NOP,          32'h80);

    // Reset values while rst_n is held low.
    #12;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, NOP, 32'h0));
    #1 checkOutput("reset_state");

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a WAIT, with no clock edge.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 32'h84, 0, NOP, 32'h80));
    #1 checkOutput("pre_reset_wait");
    #1 rst_n = 1'b0;
    sb.push_back('{req: 1'b0, addr: 32'h0, idv: 1'b0, idi: NOP, idpc: 32'h0});
    #1 checkOutput("async_reset");

    // Release; a stale rvalid arriving while in REQ must be ignored.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(0, 1, 32'hFFFFFFFF, 0, 0, 0, 1, 32'h0, 0, NOP, 32'h0));
    #1 checkOutput("post_reset_req");
    @(negedge clk);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 32'h0, 0, NOP, 32'h0));
    #1 checkOutput("stale_rvalid_ignored");
    @(negedge clk);
    applyStimulus(mk(0, 1, 32'h00500093, 0, 0, 0, 0, 32'h0, 0, NOP, 32'h0));
    #1 checkOutput("refetch_wait");
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h00500093, 32'h0));
    #1 checkOutput("refetch_deliver");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: XLEN, default 32, datapath and PC width.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter: NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented on bubbles.
REQ-004 Port list; one clock; reset is asynchronous and active-low:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address, word aligned.
- imem_gnt  input  1  request accepted this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  returned instruction word.
- redirect_valid  input  1  branch/jump/flush redirect.
- redirect_pc  input  XLEN  redirect target.
- stall  input  1  decode not accepting; hold outputs.
- id_valid  output  1  id_instr/id_pc hold a real instruction.
- id_instr  output  32  instruction to decode/immediate generation.
- id_pc  output  XLEN  address of id_instr.

Function
REQ-005 At most one imem transaction outstanding; FSM states REQ, WAIT, HOLD.
REQ-006 REQ: imem_req=1, imem_addr=pc; on imem_gnt -> WAIT, else stay.
REQ-007 WAIT: imem_req=0; on imem_rvalid with stall=0: id_valid<=1, id_instr<=imem_rdata, id_pc<=pc, pc<=pc+4, -> REQ.
REQ-008 WAIT, imem_rvalid with stall=1: capture imem_rdata and pc into a one-entry buffer, -> HOLD; id outputs unchanged.
REQ-009 HOLD: imem_req=0; when stall=0, id regs load from buffer (id_valid=1), pc<=pc+4, -> REQ.
REQ-010 stall=1: id_valid, id_instr, id_pc hold their values (except redirect, REQ-013).
REQ-011 stall=0 and no instruction delivered this cycle: id_valid<=0, id_instr<=NOP_INSTR, id_pc unchanged.
REQ-012 pc+4 wraps modulo 2^XLEN; imem_addr[1:0] always 2'b00.
REQ-013 redirect_valid has top priority and overrides stall: next edge id_valid<=0, id_instr<=NOP_INSTR, pc<={redirect_pc[XLEN-1:2],2'b00}.
REQ-014 Redirect in REQ without imem_gnt: stay REQ, new address on imem_addr next cycle.
REQ-015 Redirect in REQ with imem_gnt same cycle, or in WAIT without imem_rvalid: -> WAIT with kill flag set; the next imem_rvalid is discarded, kill cleared, -> REQ.
REQ-016 Redirect in WAIT coincident with imem_rvalid: data discarded, -> REQ, kill not set.
REQ-017 Redirect in HOLD: buffer dropped, -> REQ.
REQ-018 Discarded (killed) data never reaches id outputs and never advances pc.
REQ-019 imem_req and imem_addr are registered-state functions only; no combinational path from imem_rvalid/imem_rdata to imem_req.

Reset
REQ-020 rst_n low asynchronously forces: state=REQ, pc=RESET_PC, kill=0, buffer empty, id_valid=0, id_instr=NOP_INSTR, id_pc=0, imem_req=0.
REQ-021 imem_req first asserts in the first cycle after rst_n deasserts; reset mid-transaction abandons it, and any later imem_rvalid for it is ignored while state is REQ.

Verification
REQ-022 Reset release, imem_gnt always 1, imem_rvalid 1 cycle after grant, rdata=32'h00500093 -> imem_addr 0,4,8...; id_valid=1, id_pc=0, id_instr=32'h00500093 two cycles after first request.
REQ-023 stall=1 held 3 cycles while rvalid returns word at pc 0x8 -> id outputs frozen, HOLD entered; after stall drop id_pc=0x8 next edge, then fetch of 0xC.
REQ-024 redirect_valid with redirect_pc=0x103 while in WAIT -> killed response dropped, id_valid=0/id_instr=0x00000013, next imem_addr=0x100.
REQ-025 redirect and imem_rvalid same cycle, stall=1 -> data dropped, id_valid=0, next request to redirect target.
REQ-026 pc=32'hFFFF_FFFC fetched -> next imem_addr=0x0.
REQ-027 rst_n asserted mid-WAIT -> all outputs at reset values immediately, without a clock edge.
